uart_byte_receiver: RTL and testbench



---
 rtl/uart_byte_receiver.sv | 176 +++++++++++++++++
 tb/tb_uart_byte_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_receiver.sv
`timescale 1ns/1ps
// uart_byte_receiver
// -----------------------------------------------------------------------------
// Receives 8N1 serial characters for the instruction loader. The receiver has
// three parts:
//   - a two-flop synchronizer for rxd,
//   - a bit timer that samples each bit near its centre,
//   - a shifter that collects the data bits LSB first.
// A byte is passed on only when its stop bit is high. When the stop bit is low,
// the receiver raises frame_error for one cycle and then ignores the line until
// rxd goes high again.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (4..65535)
//   HALF_BIT      cycles from start-edge detection to the mid-start-bit sample
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low
//   rxd            raw serial line, idle high, asynchronous to clk
//   received_data  last correctly received byte
//   data_valid     one-cycle pulse, received_data was updated this cycle
//   frame_error    one-cycle pulse, the stop bit was sampled low
//   busy           high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] received_data,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam logic [15:0] C_HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_sync1, r_sync2;
    logic        w_rx_s;
    logic [15:0] r_cnt, w_cnt_next;
    logic [2:0]  r_bit_idx, w_bit_idx_next;
    logic [7:0]  r_shift, w_shift_next;
    logic [7:0]  r_data, w_data_next;
    logic        r_valid, w_valid_next;
    logic        r_ferr, w_ferr_next;

    assign w_rx_s = r_sync2;

    // The synchronizer resets to the idle (high) line level, so leaving reset
    // does not look like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_ferr    <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + 16'd1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_data_next    = r_data;
        w_valid_next   = 1'b0;
        w_ferr_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = 16'd0;
                if (!w_rx_s) begin
                    w_state_next = S_START;
                end
            end

            // Check the line again at the middle of the start bit. If it is
            // high, the low level was a glitch and it is ignored.
            S_START: begin
                if (r_cnt == C_HALF_LAST) begin
                    w_cnt_next = 16'd0;
                    if (w_rx_s) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_bit_idx_next = 3'd0;
                        w_state_next   = S_DATA;
                    end
                end
            end

            // All later samples are taken one full bit period apart, starting
            // from the centre of the start bit.
            S_DATA: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_next              = 16'd0;
                    w_shift_next[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end

            // Return to IDLE half a bit before the next start bit is due, so
            // back-to-back frames are not missed.
            S_STOP: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_next = 16'd0;
                    if (w_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end

            // Wait here until the line goes high, so a line held low produces
            // only one frame_error.
            S_BREAK: begin
                w_cnt_next = 16'd0;
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_cnt_next   = 16'd0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign received_data = r_data;
    assign data_valid    = r_valid;
    assign frame_error   = r_ferr;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
`timescale 1ns/1ps
module tb_uart_byte_receiver;

    localparam int CPB    = 16;
    localparam int HALF   = CPB / 2;
    localparam int CLK_NS = 10;
    localparam int BIT_NS = CPB * CLK_NS;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rxd   = 1'b1;
    logic [7:0] received_data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    uart_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (reset),
        .rxd           (rxd),
        .received_data (received_data),
        .data_valid    (data_valid),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #(CLK_NS / 2) clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Monitor: records every strobe seen on the outputs.
    logic [7:0] got_q[$];
    time        valid_t[$];
    int         ferr_cnt  = 0;
    logic [7:0] ferr_data = 8'h00;
    int         both_cnt  = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (data_valid) begin
                got_q.push_back(received_data);
                valid_t.push_back($time);
            end
            if (frame_error) begin
                ferr_cnt  = ferr_cnt + 1;
                ferr_data = received_data;
            end
            if (data_valid && frame_error) both_cnt = both_cnt + 1;
        end
    end

    // Reference model: each frame with a high stop bit delivers its byte, and
    // each frame with a low stop bit produces one frame error.
    logic [7:0] exp_q[$];
    int         exp_ferr  = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bits(input logic [9:0] frame, input int n, input int bit_ns);
        for (int i = 0; i < n; i++) begin
            rxd = frame[i];
            #(bit_ns);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int bit_ns);
        drive_bits({stop, b, 1'b0}, 10, bit_ns);
        if (stop) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic idle(input int ns);
        rxd = 1'b1;
        #(ns);
    endtask

    task automatic compare_rx(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            $display("%s: byte %0d got=0x%02h exp=0x%02h", tag, i, got_q[i], exp_q[i]);
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
        valid_t.delete();
    endtask

    logic [7:0] fixed_bytes[8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78};

    initial begin
        logic [7:0] b;
        logic       stop;
        time        t0;
        time        lat;
        time        min_gap;

        // Reset state
        reset = 1'b0;
        rxd   = 1'b1;
        #23;
        check("rst_data", 32'(received_data), 32'h00);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_ferr", 32'(frame_error), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #2;

        // 1: single clean frame, latency about 9.5*CPB+3 cycles (+/-1 cycle)
        t0 = $time;
        send_byte(8'hA5, 1'b1, BIT_NS);
        idle(2 * BIT_NS);
        lat = (valid_t.size() > 0) ? valid_t[0] - t0 : 0;
        $display("t1: latency_ns=%0t", lat);
        check("t1_latency_in_window",
              32'((lat >= time'((19 * CPB / 2 + 2) * CLK_NS)) && (lat <= time'((19 * CPB / 2 + 4) * CLK_NS))), 32'h1);
        check("t1_busy_idle", 32'(busy), 32'h0);
        check("t1_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        compare_rx("t1");

        // 2: back-to-back frames with one stop bit each
        for (int i = 0; i < 8; i++) send_byte(fixed_bytes[i], 1'b1, BIT_NS);
        idle(2 * BIT_NS);
        min_gap = 64'hFFFF_FFFF;
        for (int i = 1; i < valid_t.size(); i++)
            if (valid_t[i] - valid_t[i-1] < min_gap) min_gap = valid_t[i] - valid_t[i-1];
        check("t2_min_gap_ok", 32'(min_gap >= time'(10 * BIT_NS)), 32'h1);
        check("t2_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        compare_rx("t2");

        // 2b: random bytes, some frames with a bad stop bit
        for (int i = 0; i < 12; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_byte(b, stop, BIT_NS);
            if (!stop) idle(2 * BIT_NS);
        end
        idle(2 * BIT_NS);
        check("t2r_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        check("t2r_both", 32'(both_cnt), 32'h0);
        compare_rx("t2r");

        // 3: a short glitch is rejected
        rxd = 1'b0;
        #(4 * CLK_NS);
        check("t3_busy_start", 32'(busy), 32'h1);
        rxd = 1'b1;
        #((HALF + 3) * CLK_NS);
        check("t3_busy_back", 32'(busy), 32'h0);
        idle(2 * BIT_NS);
        check("t3_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        compare_rx("t3");

        // 4: bad stop bit, line held low, then a good frame
        send_byte(8'h3C, 1'b0, BIT_NS);
        rxd = 1'b0;
        #(50 * CLK_NS);
        idle(2 * BIT_NS);
        check("t4_ferr_count", 32'(ferr_cnt), 32'(exp_ferr));
        check("t4_ferr_data_held", 32'(ferr_data), 32'(last_good));
        check("t4_data_held", 32'(received_data), 32'(last_good));
        send_byte(8'h5A, 1'b1, BIT_NS);
        idle(2 * BIT_NS);
        compare_rx("t4");

        // 5: asynchronous reset during data bit 4 of 0xC3
        drive_bits({1'b1, 8'hC3, 1'b0}, 5, BIT_NS);
        rxd = 1'b0;
        #(BIT_NS / 2);
        reset = 1'b0;
        #1;
        check("t5_rst_data", 32'(received_data), 32'h00);
        check("t5_rst_valid", 32'(data_valid), 32'h0);
        check("t5_rst_ferr", 32'(frame_error), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #2;
        idle(2 * BIT_NS);
        send_byte(8'h81, 1'b1, BIT_NS);
        idle(2 * BIT_NS);
        check("t5_data_after", 32'(received_data), 32'h81);
        compare_rx("t5");

        // 6: about +/-3% baud skew (bit period 15.5 and 16.5 clocks)
        send_byte(8'h55, 1'b1, BIT_NS - 5);
        idle(2 * BIT_NS);
        send_byte(8'hAA, 1'b1, BIT_NS - 5);
        idle(2 * BIT_NS);
        send_byte(8'h55, 1'b1, BIT_NS + 5);
        idle(2 * BIT_NS);
        send_byte(8'hAA, 1'b1, BIT_NS + 5);
        idle(2 * BIT_NS);
        check("t6_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        check("t6_both", 32'(both_cnt), 32'h0);
        compare_rx("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
